// File: rtl/pc_stack_unit.sv
// Paged program counter with a hardware return-address stack.
// Priority: stall > ret > call > long_jump > branch > sequential increment.
module pc_stack_unit #(
  parameter int PC_W        = 10,
  parameter int PAGE_W      = 8,
  parameter int STACK_DEPTH = 4,
  parameter int INC_MODE    = 0,
  localparam int SP_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 start_n,
  input  logic [PC_W-1:0]      start_address,
  input  logic                 stall,
  input  logic                 branch,
  input  logic [PAGE_W-1:0]    br_target,
  input  logic                 long_jump,
  input  logic [PC_W-PAGE_W-1:0] lj_page,
  input  logic [PAGE_W-1:0]    lj_offset,
  input  logic                 call,
  input  logic [PC_W-1:0]      call_target,
  input  logic                 ret,
  output logic [PC_W-1:0]      rp,
  output logic [SP_W-1:0]      sp,
  output logic                 stack_ovf,
  output logic                 stack_unf
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [PC_W-1:0]  rp_q, rp_d;
  logic [SP_W-1:0]  sp_q, sp_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [PC_W-1:0]  inc_pc;
  logic             push_en;
  logic [IDX_W-1:0] push_idx, pop_idx;
  logic             stack_full, stack_empty;
  logic [PC_W-1:0]  stack_q [2**IDX_W];

  generate
    if (INC_MODE == 0) begin : g_inc_page
      assign inc_pc = {rp_q[PC_W-1:PAGE_W], rp_q[PAGE_W-1:0] + PAGE_W'(1)};
    end else begin : g_inc_full
      assign inc_pc = rp_q + PC_W'(1);
    end
  endgenerate

  // sp-1 modulo the index width equals sp-1 whenever sp > 0, so no wide subtract is needed.
  assign push_idx    = sp_q[IDX_W-1:0];
  assign pop_idx     = push_idx - IDX_W'(1);
  assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp_q == '0);

  always_comb begin
    rp_d    = rp_q;
    sp_d    = sp_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push_en = 1'b0;
    if (!stall) begin
      if (ret) begin
        if (!stack_empty) begin
          rp_d = stack_q[pop_idx];
          sp_d = sp_q - SP_W'(1);
        end else begin
          unf_d = 1'b1;
          rp_d  = inc_pc;
        end
      end else if (call) begin
        rp_d = call_target;
        if (!stack_full) begin
          push_en = 1'b1;
          sp_d    = sp_q + SP_W'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end else if (long_jump) begin
        rp_d = {lj_page, lj_offset};
      end else if (branch) begin
        rp_d = {rp_q[PC_W-1:PAGE_W], br_target};
      end else begin
        rp_d = inc_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!start_n) begin
      rp_q  <= start_address;
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      rp_q  <= rp_d;
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Stack storage carries no reset; entries above sp are never read.
  always_ff @(posedge clk) begin
    if (start_n && push_en) begin
      stack_q[push_idx] <= inc_pc;
    end
  end

  assign rp        = rp_q;
  assign sp        = sp_q;
  assign stack_ovf = ovf_q;
  assign stack_unf = unf_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Randomised scoreboard bench for pc_stack_unit: one instance per increment mode,
// both fed the same commands and checked against a queue-based reference model.
module tb_pc_stack_unit;

  logic       clk = 1'b0;
  logic       start_n;
  logic [9:0] start_address;
  logic       stall, branch, long_jump, call, ret;
  logic [7:0] br_target, lj_offset;
  logic [1:0] lj_page;
  logic [9:0] call_target;

  logic [9:0] rp0, rp1;
  logic [2:0] sp0, sp1;
  logic       ovf0, ovf1, unf0, unf1;

  int checks = 0;
  int errors = 0;

  logic [29:0] exp_q[$];

  // Reference model state, one slot per increment mode.
  int         m_rp[2];
  bit         m_ovf[2];
  bit         m_unf[2];
  logic [9:0] stk0[$];
  logic [9:0] stk1[$];

  pc_stack_unit #(.PC_W(10), .PAGE_W(8), .STACK_DEPTH(4), .INC_MODE(0)) u_dut0 (
    .clk(clk), .start_n(start_n), .start_address(start_address), .stall(stall),
    .branch(branch), .br_target(br_target), .long_jump(long_jump), .lj_page(lj_page),
    .lj_offset(lj_offset), .call(call), .call_target(call_target), .ret(ret),
    .rp(rp0), .sp(sp0), .stack_ovf(ovf0), .stack_unf(unf0)
  );

  pc_stack_unit #(.PC_W(10), .PAGE_W(8), .STACK_DEPTH(4), .INC_MODE(1)) u_dut1 (
    .clk(clk), .start_n(start_n), .start_address(start_address), .stall(stall),
    .branch(branch), .br_target(br_target), .long_jump(long_jump), .lj_page(lj_page),
    .lj_offset(lj_offset), .call(call), .call_target(call_target), .ret(ret),
    .rp(rp1), .sp(sp1), .stack_ovf(ovf1), .stack_unf(unf1)
  );

  // Clock
  always #5 clk = ~clk;

  // Reference model
  function automatic int inc_of(int m, int pc);
    if (m == 0) return (pc & 'h300) | ((pc + 1) & 'hFF);
    return (pc + 1) & 'h3FF;
  endfunction

  function automatic int stk_size(int m);
    return (m == 0) ? stk0.size() : stk1.size();
  endfunction

  function automatic void stk_push(int m, int v);
    if (m == 0) stk0.push_back(10'(v));
    else        stk1.push_back(10'(v));
  endfunction

  function automatic int stk_pop(int m);
    if (m == 0) return int'(stk0.pop_back());
    return int'(stk1.pop_back());
  endfunction

  function automatic void stk_clear(int m);
    if (m == 0) stk0.delete();
    else        stk1.delete();
  endfunction

  task automatic model_step(int m, bit rst, int sa, bit st, bit rt, bit cl, bit lj,
                            bit br, int br_t, int cl_t, int lj_p, int lj_o);
    if (rst) begin
      m_rp[m] = sa; m_ovf[m] = 0; m_unf[m] = 0; stk_clear(m);
    end else if (st) begin
      // everything held
    end else if (rt) begin
      if (stk_size(m) > 0) m_rp[m] = stk_pop(m);
      else begin m_unf[m] = 1; m_rp[m] = inc_of(m, m_rp[m]); end
    end else if (cl) begin
      if (stk_size(m) < 4) stk_push(m, inc_of(m, m_rp[m]));
      else m_ovf[m] = 1;
      m_rp[m] = cl_t;
    end else if (lj) begin
      m_rp[m] = lj_p * 256 + lj_o;
    end else if (br) begin
      m_rp[m] = (m_rp[m] & 'h300) | br_t;
    end else begin
      m_rp[m] = inc_of(m, m_rp[m]);
    end
  endtask

  function automatic logic [14:0] pack_exp(int m);
    return {10'(m_rp[m]), 3'(stk_size(m)), m_ovf[m], m_unf[m]};
  endfunction

  // Driver: one command per cycle, applied on the falling edge.
  task automatic cyc(bit rst, int sa, bit st, bit rt, bit cl, bit lj, bit br,
                     int br_t, int cl_t, int lj_p, int lj_o, bit xcmd);
    @(negedge clk);
    start_n       = ~rst;
    start_address = 10'(sa);
    if (xcmd) begin
      stall = 'x; ret = 'x; call = 'x; long_jump = 'x; branch = 'x;
      br_target = 'x; call_target = 'x; lj_page = 'x; lj_offset = 'x;
    end else begin
      stall = st; ret = rt; call = cl; long_jump = lj; branch = br;
      br_target = 8'(br_t); call_target = 10'(cl_t); lj_page = 2'(lj_p); lj_offset = 8'(lj_o);
    end
    for (int m = 0; m < 2; m++) model_step(m, rst, sa, st, rt, cl, lj, br, br_t, cl_t, lj_p, lj_o);
    exp_q.push_back({pack_exp(0), pack_exp(1)});
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic do_rst(int sa);      cyc(1, sa, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic do_br(int t);        cyc(0, 0, 0, 0, 0, 0, 1, t, 0, 0, 0, 0); endtask
  task automatic do_lj(int p, int o); cyc(0, 0, 0, 0, 0, 1, 0, 0, 0, p, o, 0); endtask
  task automatic do_call(int t);      cyc(0, 0, 0, 0, 1, 0, 0, 0, t, 0, 0, 0); endtask
  task automatic do_ret();            cyc(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0); endtask

  // Monitor / scoreboard: outputs are registered, so one expected entry per cycle.
  always @(posedge clk) begin
    logic [29:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({rp0, sp0, ovf0, unf0} !== e[29:15]) begin
        errors++;
        $display("FAIL mode0 t=%0t actual rp=%h sp=%0d ovf=%b unf=%b required rp=%h sp=%0d ovf=%b unf=%b",
                 $time, rp0, sp0, ovf0, unf0, e[29:20], e[19:17], e[16], e[15]);
      end
      checks++;
      if ({rp1, sp1, ovf1, unf1} !== e[14:0]) begin
        errors++;
        $display("FAIL mode1 t=%0t actual rp=%h sp=%0d ovf=%b unf=%b required rp=%h sp=%0d ovf=%b unf=%b",
                 $time, rp1, sp1, ovf1, unf1, e[14:5], e[4:2], e[1], e[0]);
      end
    end
  end

  initial begin
    start_n = 1'b0; start_address = '0; stall = 0; branch = 0; long_jump = 0;
    call = 0; ret = 0; br_target = '0; lj_page = '0; lj_offset = '0; call_target = '0;

    // Reset and sequential increment
    do_rst('h155);
    idle(2);
    // Wrap behaviour at the page and PC boundaries
    do_lj(1, 'hFF); idle(1);
    do_lj(3, 'hFF); idle(1);
    // Branch and long jump
    do_lj(2, 'hA0); do_br('h17); do_lj(3, 'h40);
    // Nested call / return
    do_lj(0, 'h10); do_call('h200); idle(5); do_call('h300); do_ret(); do_ret();
    // Stack limits
    do_rst('h000);
    do_call('h100); do_call('h110); do_call('h120); do_call('h130); do_call('h140);
    for (int i = 0; i < 5; i++) do_ret();
    idle(3);
    // Simultaneous strobes
    cyc(0, 0, 0, 0, 1, 0, 1, 'h55, 'h2C0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 'h0AB, 1, 1, 1, 1, 1, 'h11, 'h222, 1, 'h33, 0);
    // Reset with unknown command inputs
    cyc(1, 'h3F0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(2);

    // Randomised command mix
    for (int i = 0; i < 3000; i++) begin
      bit rst;
      rst = ($urandom_range(0, 99) < 2);
      cyc(rst, $urandom_range(0, 1023),
          ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 25),
          ($urandom_range(0, 99) < 25), ($urandom_range(0, 99) < 10),
          ($urandom_range(0, 99) < 15),
          $urandom_range(0, 255), $urandom_range(0, 1023),
          $urandom_range(0, 3), $urandom_range(0, 255),
          rst && ($urandom_range(0, 1) == 1));
    end

    @(negedge clk);
    stall = 1'b1;
    @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual %0d entries left required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
